// File: rtl/vector_fetch_sequencer.sv
// Vector fetch sequencer: streams paired operand vectors from two synchronous-read
// memories to the dot-product stage, one element pair per cycle, and waits for the
// consumer to acknowledge each vector before fetching the next one.
module vector_fetch_sequencer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned VECTOR_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr1,
  input  logic [ADDR_WIDTH-1:0] base_addr2,
  input  logic [ADDR_WIDTH-1:0] num_vectors,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem1_addr,
  output logic [ADDR_WIDTH-1:0] mem2_addr,
  input  logic [DATA_WIDTH-1:0] mem1_rdata,
  input  logic [DATA_WIDTH-1:0] mem2_rdata,
  output logic [DATA_WIDTH-1:0] mem1_output,
  output logic [DATA_WIDTH-1:0] mem2_output,
  output logic                  data_valid,
  input  logic                  processing_done,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int unsigned BEAT_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base1_q, base1_d;
  logic [ADDR_WIDTH-1:0]   base2_q, base2_d;
  logic [ADDR_WIDTH-1:0]   nvec_q, nvec_d;
  logic [ADDR_WIDTH-1:0]   vcnt_q, vcnt_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
  logic [ADDR_WIDTH-1:0]   addr2_q, addr2_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tmo_q, tmo_d;
  logic [MEM_LATENCY-1:0]  pipe_q, pipe_d;
  logic                    dv_q, dv_d;
  logic [DATA_WIDTH-1:0]   out1_q, out1_d;
  logic [DATA_WIDTH-1:0]   out2_q, out2_d;

  // Control FSM: job acceptance, beat issue, result wait with timeout, completion pulse
  always_comb begin
    state_d = state_q;
    base1_d = base1_q;
    base2_d = base2_q;
    nvec_d  = nvec_q;
    vcnt_d  = vcnt_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    rd_en_d = 1'b0;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base1_d = base_addr1;
          base2_d = base_addr2;
          nvec_d  = num_vectors;
          vcnt_d  = '0;
          beat_d  = '0;
          busy_d  = 1'b1;
          tmo_d   = 1'b0;
          state_d = (num_vectors == '0) ? ST_DONE : ST_FETCH;
        end
      end

      ST_FETCH: begin
        rd_en_d = 1'b1;
        addr1_d = base1_q + ADDR_WIDTH'(beat_q);
        addr2_d = base2_q + ADDR_WIDTH'(beat_q);
        if (beat_q == BEAT_W'(VECTOR_WIDTH - 1)) begin
          beat_d  = '0;
          wait_d  = '0;
          state_d = ST_WAIT;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      ST_WAIT: begin
        // An acknowledge on the timeout cycle still counts as a normal completion
        if (processing_done) begin
          vcnt_d  = vcnt_q + ADDR_WIDTH'(1);
          base1_d = base1_q + ADDR_WIDTH'(VECTOR_WIDTH);
          base2_d = base2_q + ADDR_WIDTH'(VECTOR_WIDTH);
          state_d = ((vcnt_q + ADDR_WIDTH'(1)) == nvec_q) ? ST_DONE : ST_FETCH;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-latency pipe: data path follows the read strobe, independent of the FSM
  always_comb begin
    pipe_d = MEM_LATENCY'({pipe_q, rd_en_q});
    dv_d   = pipe_q[MEM_LATENCY-1];
    out1_d = out1_q;
    out2_d = out2_q;
    if (pipe_q[MEM_LATENCY-1]) begin
      out1_d = mem1_rdata;
      out2_d = mem2_rdata;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base1_q <= '0;
      base2_q <= '0;
      nvec_q  <= '0;
      vcnt_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      rd_en_q <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      pipe_q  <= '0;
      dv_q    <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      base1_q <= base1_d;
      base2_q <= base2_d;
      nvec_q  <= nvec_d;
      vcnt_q  <= vcnt_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rd_en_q <= rd_en_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      pipe_q  <= pipe_d;
      dv_q    <= dv_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem1_addr   = addr1_q;
  assign mem2_addr   = addr2_q;
  assign mem1_output = out1_q;
  assign mem2_output = out2_q;
  assign data_valid  = dv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_vector_fetch_sequencer.sv
// Directed bench for vector_fetch_sequencer with a synchronous-read memory model.
module tb_vector_fetch_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr1, base_addr2, num_vectors;
  logic          mem_rd_en;
  logic [AW-1:0] mem1_addr, mem2_addr;
  logic [DW-1:0] mem1_rdata = '0;
  logic [DW-1:0] mem2_rdata = '0;
  logic [DW-1:0] mem1_output, mem2_output;
  logic          data_valid;
  logic          processing_done;
  logic          busy, done, timeout_err;

  vector_fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr1      (base_addr1),
    .base_addr2      (base_addr2),
    .num_vectors     (num_vectors),
    .mem_rd_en       (mem_rd_en),
    .mem1_addr       (mem1_addr),
    .mem2_addr       (mem2_addr),
    .mem1_rdata      (mem1_rdata),
    .mem2_rdata      (mem2_rdata),
    .mem1_output     (mem1_output),
    .mem2_output     (mem2_output),
    .data_valid      (data_valid),
    .processing_done (processing_done),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  // Operand memories, one-cycle synchronous read
  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] mem2 [32];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem1_rdata <= mem1[mem1_addr];
      mem2_rdata <= mem2[mem2_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation logs sampled on the falling edge
  int rd_a1[$], rd_a2[$], rd_c[$];
  int dv_1[$], dv_2[$], dv_c[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) begin
      rd_a1.push_back(int'(mem1_addr));
      rd_a2.push_back(int'(mem2_addr));
      rd_c.push_back(cyc);
    end
    if (data_valid === 1'b1) begin
      dv_1.push_back(int'(mem1_output));
      dv_2.push_back(int'(mem2_output));
      dv_c.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
  end

  int n_checks = 0;
  int n_err    = 0;
  int s_cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_a1.delete(); rd_a2.delete(); rd_c.delete();
    dv_1.delete();  dv_2.delete();  dv_c.delete();
  endtask

  task automatic do_start(input int b1, input int b2, input int n);
    tick();
    base_addr1  = AW'(b1);
    base_addr2  = AW'(b2);
    num_vectors = AW'(n);
    start       = 1'b1;
    s_cyc       = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int limit);
    for (int i = 0; i < limit && rd_c.size() < n; i++) tick();
    chk("rd_count", rd_c.size(), n);
  endtask

  task automatic wait_dv(input int n, input int limit);
    for (int i = 0; i < limit && dv_c.size() < n; i++) tick();
    chk("dv_count", dv_c.size(), n);
  endtask

  task automatic pulse_pd();
    processing_done = 1'b1;
    tick();
    processing_done = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done !== 1'b1; i++) tick();
    chk("done_pulse", done, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    int d0;
    for (int i = 0; i < 32; i++) begin
      mem1[i] = DW'(i + 1);
      mem2[i] = DW'(i + 1);
    end
    rst = 1'b1; start = 1'b0; processing_done = 1'b0;
    base_addr1 = '0; base_addr2 = '0; num_vectors = '0;
    tick(); tick();

    // Reset state
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    tick();

    // Single vector, base1=0 base2=16
    clear_logs();
    do_start(0, 16, 1);
    chk("sv_busy", busy, 1);
    wait_rd(4, 20);
    wait_dv(4, 20);
    chk("sv_first_rd_latency", rd_c[0], s_cyc + 2);
    for (int i = 0; i < 4; i++) begin
      chk("sv_a1", rd_a1[i], i);
      chk("sv_a2", rd_a2[i], 16 + i);
      chk("sv_d1", dv_1[i], i + 1);
      chk("sv_d2", dv_2[i], 17 + i);
      chk("sv_dv_lat", dv_c[i] - rd_c[i], 2);
    end
    chk("sv_done_early", done, 0);
    chk("sv_busy_wait", busy, 1);
    pulse_pd();
    chk("sv_done_not_yet", done, 0);
    tick();
    chk("sv_done", done, 1);
    chk("sv_busy_low", busy, 0);
    tick();
    chk("sv_done_clear", done, 0);

    // Two vectors with address wrap on memory 1
    clear_logs();
    do_start(28, 4, 2);
    wait_rd(4, 20);
    repeat (10) tick();
    chk("mv_no_early_fetch", rd_c.size(), 4);
    pulse_pd();
    wait_rd(8, 20);
    wait_dv(8, 20);
    for (int i = 0; i < 8; i++) begin
      chk("mv_a1", rd_a1[i], (28 + i) % 32);
      chk("mv_a2", rd_a2[i], 4 + i);
      chk("mv_d1", dv_1[i], ((28 + i) % 32) + 1);
      chk("mv_d2", dv_2[i], 5 + i);
    end
    pulse_pd();
    wait_done(10);

    // Zero-vector job
    clear_logs();
    do_start(0, 0, 0);
    chk("n0_busy", busy, 1);
    tick();
    chk("n0_done", done, 1);
    chk("n0_done_cycle", cyc, s_cyc + 2);
    tick();
    chk("n0_done_clear", done, 0);
    chk("n0_busy_low", busy, 0);
    chk("n0_no_reads", rd_c.size(), 0);

    // Timeout: never acknowledge
    clear_logs();
    do_start(8, 8, 1);
    wait_rd(4, 20);
    lc = rd_c[3];
    for (int i = 0; i < 100 && timeout_err !== 1'b1; i++) tick();
    chk("to_flag", timeout_err, 1);
    chk("to_cycle", cyc, lc + 64);
    chk("to_done_not_yet", done, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_done_cycle", cyc, lc + 65);
    tick();
    chk("to_sticky", timeout_err, 1);
    chk("to_busy_low", busy, 0);

    // New start clears the flag; start and processing_done while fetching are ignored
    clear_logs();
    d0 = done_cnt;
    do_start(0, 16, 1);
    chk("ig_tmo_cleared", timeout_err, 0);
    start = 1'b1; base_addr1 = AW'(20); num_vectors = '0; processing_done = 1'b1;
    tick();
    start = 1'b0; processing_done = 1'b0;
    wait_rd(4, 20);
    repeat (8) tick();
    chk("ig_rd_total", rd_c.size(), 4);
    for (int i = 0; i < 4; i++) chk("ig_a1", rd_a1[i], i);
    chk("ig_busy", busy, 1);
    chk("ig_no_done", done_cnt, d0);
    pulse_pd();
    wait_done(10);

    // Reset in the middle of a job
    clear_logs();
    do_start(0, 16, 2);
    for (int i = 0; i < 10 && data_valid !== 1'b1; i++) tick();
    chk("mr_dv_before", data_valid, 1);
    chk("mr_rd_before", mem_rd_en, 1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("mr_rd_en", mem_rd_en, 0);
    chk("mr_dv", data_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("mr_no_done", done_cnt, d0);
    chk("mr_busy_after", busy, 0);
    chk("mr_rd_after", mem_rd_en, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
